// File: rtl/m_mem_pkg.sv
// m_mem_pkg: shared definitions for the M-stage data-memory controller.
//   - M_op access opcodes (0 none, 1..8 loads/stores, 9..15 treated as none)
//   - controller FSM state encoding
//   - byte-enable constants
//   - helpers that classify opcodes and build byte enables / store data
package m_mem_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_access(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_SB);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SB);
    endfunction

    // Byte lanes touched by an access; loads use the same lane pattern as
    // the store of equal width.
    function automatic logic [3:0] access_be(input logic [3:0] op, input logic [1:0] a);
        logic [3:0] be;
        case (op)
            OP_LW, OP_SW:          be = BE_WORD;
            OP_LH, OP_LHU, OP_SH:  be = a[1] ? BE_HALF_HI : BE_HALF_LO;
            OP_LB, OP_LBU, OP_SB:  be = BE_BYTE0 << a;
            default:               be = BE_NONE;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so the enabled lanes carry it.
    function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] w;
        case (op)
            OP_SH:   w = {2{d[15:0]}};
            OP_SB:   w = {4{d[7:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        logic m;
        case (op)
            OP_LW, OP_SW:         m = (a != 2'b00);
            OP_LH, OP_LHU, OP_SH: m = a[0];
            default:              m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/m_dmem_ctrl_load_extender.sv
// load_extender: combinational load alignment and extension.
//   op     - M_op load opcode (LW/LH/LHU/LB/LBU; others pass the word through)
//   addr   - byte offset within the word
//   rdata  - raw word returned by memory
//   result - selected byte/half, sign- or zero-extended to 32 bits
module load_extender
    import m_mem_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (op)
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'h0000, half_sel};
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'h000000, byte_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/m_dmem_ctrl.sv
// m_dmem_ctrl: M-stage data-memory controller.
// Turns a load/store in the M stage into a single request/acknowledge
// transaction on the memory side, stalling the pipeline until the ack
// arrives, then presents the aligned load result for one cycle.
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   M_valid, M_op, M_ans       - M-stage valid, access opcode, byte address
//   M_Rdata2, M_pc             - store data, PC of the M-stage instruction
//   mem_req/we/addr/wdata/be   - memory request side (addr word-aligned)
//   mem_ack, mem_rdata         - memory response side
//   M_stall                    - freezes PC/F/D/E/M registers
//   W_ld_data, W_ld_valid      - load result and its one-cycle strobe
//   M_exc, M_exc_pc            - misaligned-access report
//
// Build option: define M_DMEM_ALIGN_EXC_EN to trap misaligned word/half
// accesses instead of issuing them; otherwise the low address bits that
// would be misaligned are ignored and M_exc/M_exc_pc are tied to 0.
module m_dmem_ctrl
    import m_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        M_valid,
    input  logic [3:0]  M_op,
    input  logic [31:0] M_ans,
    input  logic [31:0] M_Rdata2,
    input  logic [31:0] M_pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        M_stall,
    output logic [31:0] W_ld_data,
    output logic        W_ld_valid,
    output logic        M_exc,
    output logic [31:0] M_exc_pc
);

    state_e      state, state_nxt;
    logic        access, misalign, start;
    logic [3:0]  op_q, be_q;
    logic [31:0] addr_q, wdata_q, ld_data_q, ext_result;

    assign access = M_valid && is_access(M_op);

`ifdef M_DMEM_ALIGN_EXC_EN
    assign misalign = access && is_misaligned(M_op, M_ans[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign start = access && !misalign;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ack is only looked at in REQ
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_REQ;
            ST_REQ:  if (mem_ack) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs; the stall is gated with rst_n so it is forced low during reset
    // even though the IDLE term is combinational on the pipeline inputs.
    always_comb begin
        mem_req    = (state == ST_REQ);
        mem_we     = mem_req && is_store(op_q);
        mem_be     = mem_req ? be_q : BE_NONE;
        W_ld_valid = (state == ST_DONE) && is_load(op_q);
        M_stall    = 1'b0;
        if (rst_n) begin
            M_stall = ((state == ST_IDLE) && start) || (state == ST_REQ);
        end
    end

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign W_ld_data = ld_data_q;

    load_extender u_load_extender (
        .op     (op_q),
        .addr   (addr_q[1:0]),
        .rdata  (mem_rdata),
        .result (ext_result)
    );

    // Access is captured on entry to REQ so the request stays stable even if
    // the M-stage inputs change (or M_valid drops) while waiting for ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_NONE;
            be_q      <= BE_NONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            ld_data_q <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                op_q    <= M_op;
                be_q    <= access_be(M_op, M_ans[1:0]);
                addr_q  <= M_ans;
                wdata_q <= store_wdata(M_op, M_Rdata2);
            end
            if ((state == ST_REQ) && mem_ack && is_load(op_q)) begin
                ld_data_q <= ext_result;
            end
        end
    end

`ifdef M_DMEM_ALIGN_EXC_EN
    logic        exc_q;
    logic [31:0] exc_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_q    <= 1'b0;
            exc_pc_q <= '0;
        end else begin
            exc_q    <= (state == ST_IDLE) && misalign;
            exc_pc_q <= ((state == ST_IDLE) && misalign) ? M_pc : '0;
        end
    end

    assign M_exc    = exc_q;
    assign M_exc_pc = exc_pc_q;
`else
    logic unused_pc;
    assign unused_pc = ^M_pc;
    assign M_exc     = 1'b0;
    assign M_exc_pc  = '0;
`endif

endmodule

// File: tb/tb_m_dmem_ctrl.sv
// tb_m_dmem_ctrl: self-checking bench for m_dmem_ctrl.
// Directed vector table plus randomized accesses checked against a
// arithmetic reference model; hand sequences cover reset mid-request and
// the misaligned-access option (M_DMEM_ALIGN_EXC_EN).
module tb_m_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        M_valid;
    logic [3:0]  M_op;
    logic [31:0] M_ans, M_Rdata2, M_pc;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        M_stall;
    logic [31:0] W_ld_data;
    logic        W_ld_valid;
    logic        M_exc;
    logic [31:0] M_exc_pc;

    int total = 0;
    int bad   = 0;
    bit exc_any = 0;

    m_dmem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .M_valid    (M_valid),
        .M_op       (M_op),
        .M_ans      (M_ans),
        .M_Rdata2   (M_Rdata2),
        .M_pc       (M_pc),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .M_stall    (M_stall),
        .W_ld_data  (W_ld_data),
        .W_ld_valid (W_ld_valid),
        .M_exc      (M_exc),
        .M_exc_pc   (M_exc_pc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (M_exc) exc_any = 1;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        logic [31:0] exp_ld;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl[8];

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input int op, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        int unsigned bsh = (addr % 4) * 8;
        int unsigned hsh = ((addr / 2) % 2) * 16;
        case (op)
            2: begin v = (rd >> hsh) & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            3: v = (rd >> hsh) & 32'hFFFF;
            4: begin v = (rd >> bsh) & 32'hFF; if (v >= 32'h80) v = v - 32'h100; end
            5: v = (rd >> bsh) & 32'hFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] model_be(input int op, input logic [31:0] addr);
        logic [3:0] b;
        case (op)
            1, 6:    b = 4'hF;
            2, 3, 7: b = ((addr / 2) % 2 == 1) ? 4'hC : 4'h3;
            default: b = 4'(1 << (addr % 4));
        endcase
        return b;
    endfunction

    function automatic logic [31:0] model_wdata(input int op, input logic [31:0] d);
        logic [31:0] w;
        case (op)
            7:       w = (d & 32'hFFFF) * 32'h0001_0001;
            8:       w = (d & 32'hFF) * 32'h0101_0101;
            default: w = d;
        endcase
        return w;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic run_txn(input string nm, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input logic [31:0] pc,
                           input int ack_at, input logic [31:0] exp_ld,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int stalls = 0;
        bit req_ok = 1;
        bit is_ld  = (op >= 1 && op <= 5);
        logic [31:0] exp_addr = addr & ~32'h3;
        // access cycle in IDLE; ack here must be ignored
        M_valid = 1; M_op = op; M_ans = addr; M_Rdata2 = wd; M_pc = pc;
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        if (M_stall) stalls++;
        if (mem_req || mem_we || mem_be != 4'h0) req_ok = 0;
        for (int k = 1; k <= ack_at; k++) begin
            @(posedge clk); #1;
            M_valid = 1'($urandom); M_op = 4'($urandom); M_ans = $urandom; M_Rdata2 = $urandom;
            mem_ack = (k == ack_at); mem_rdata = (k == ack_at) ? rd : $urandom;
            @(negedge clk);
            if (M_stall) stalls++;
            if (!(mem_req && mem_addr == exp_addr && mem_be == exp_be && mem_we == !is_ld &&
                  (is_ld || mem_wdata == exp_wd))) req_ok = 0;
        end
        // DONE
        @(posedge clk); #1;
        M_valid = 0; mem_ack = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        if (M_stall) stalls++;
        check({nm, " req"}, 32'(req_ok), 32'd1);
        check({nm, " stall"}, stalls, ack_at + 1);
        check({nm, " vld"}, 32'(W_ld_valid), 32'(is_ld));
        if (is_ld) check({nm, " data"}, W_ld_data, exp_ld);
        check({nm, " donebus"}, {mem_req, mem_we, mem_be}, 0);
        // back in IDLE: strobe gone, ack ignored
        @(posedge clk); #1;
        mem_ack = 1;
        @(negedge clk);
        check({nm, " post"}, {W_ld_valid, M_stall, mem_req, mem_we, mem_be}, 0);
        @(posedge clk); #1;
        mem_ack = 0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, wd, rd;

        tbl[0] = '{4'd1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[1] = '{4'd4, 32'h0000_0013, 32'h0,         32'h80FF_FF7F, 2, 32'hFFFF_FF80, 4'h8, 32'h0};
        tbl[2] = '{4'd5, 32'h0000_0013, 32'h0,         32'h80FF_FF7F, 1, 32'h0000_0080, 4'h8, 32'h0};
        tbl[3] = '{4'd7, 32'h0000_0022, 32'h1234_ABCD, 32'h0,         1, 32'h0,         4'hC, 32'hABCD_ABCD};
        tbl[4] = '{4'd6, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,         4, 32'h0,         4'hF, 32'hCAFE_F00D};
        tbl[5] = '{4'd2, 32'h0000_0102, 32'h0,         32'h8001_7FFF, 1, 32'hFFFF_8001, 4'hC, 32'h0};
        tbl[6] = '{4'd3, 32'h0000_0100, 32'h0,         32'h8001_F00F, 3, 32'h0000_F00F, 4'h3, 32'h0};
        tbl[7] = '{4'd8, 32'h0000_0001, 32'h0000_00A5, 32'h0,         1, 32'h0,         4'h2, 32'hA5A5_A5A5};

        // reset with an access presented: everything must stay low
        rst_n = 0; M_valid = 1; M_op = 4'd1; M_ans = 32'h10; M_Rdata2 = 32'h5555_5555;
        M_pc = 32'h1000; mem_ack = 0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outs", {mem_req, mem_we, mem_be, M_stall, W_ld_valid, M_exc}, 0);
        check("reset addr", mem_addr, 0);
        check("reset wdata", mem_wdata, 0);
        check("reset ld", W_ld_data, 0);
        check("reset excpc", M_exc_pc, 0);
        M_valid = 0;
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                    32'h2000 + 32'(i * 4), tbl[i].ack_at, tbl[i].exp_ld, tbl[i].exp_be, tbl[i].exp_wdata);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 8));
            a  = $urandom;
`ifdef M_DMEM_ALIGN_EXC_EN
            if (op == 4'd1 || op == 4'd6) a = a & ~32'h3;
            if (op == 4'd2 || op == 4'd3 || op == 4'd7) a = a & ~32'h1;
`endif
            wd = $urandom;
            rd = $urandom;
            run_txn($sformatf("rnd%0d", i), op, a, wd, rd, 32'h4000, $urandom_range(1, 3),
                    model_load(int'(op), a, rd), model_be(int'(op), a), model_wdata(int'(op), wd));
        end

        // reset asserted in the second REQ cycle
        M_valid = 1; M_op = 4'd1; M_ans = 32'h80; mem_ack = 0;
        @(negedge clk);
        @(posedge clk); #1; M_valid = 0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst pre req", 32'(mem_req), 32'd1);
        #2 rst_n = 0;
        #1;
        check("rst drop", {mem_req, M_stall, mem_we, mem_be}, 0);
        check("rst drop addr", mem_addr, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst idle", {mem_req, M_stall, W_ld_valid}, 0);
        @(posedge clk); #1;
        run_txn("rst lw", 4'd1, 32'h84, 32'h0, 32'h1357_9BDF, 32'h5000, 1,
                32'h1357_9BDF, 4'hF, 32'h0);

`ifdef M_DMEM_ALIGN_EXC_EN
        begin
            int excn = 0, reqn = 0, stn = 0;
            logic [31:0] epc = 0;
            M_valid = 1; M_op = 4'd1; M_ans = 32'h2; M_pc = 32'h3008;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (M_exc) begin excn++; epc = M_exc_pc; end
                if (mem_req) reqn++;
                if (M_stall) stn++;
                @(posedge clk); #1;
                M_valid = 0;
            end
            check("exc pulses", excn, 1);
            check("exc pc", epc, 32'h3008);
            check("exc no req", reqn, 0);
            check("exc no stall", stn, 0);
        end
`else
        run_txn("mis lw", 4'd1, 32'h2, 32'h0, 32'h2468_ACE0, 32'h3008, 1,
                32'h2468_ACE0, 4'hF, 32'h0);
        check("no exc", {31'(exc_any), M_exc}, 0);
        check("no exc pc", M_exc_pc, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/m_dmem_ctrl.md
M_DMEM_CTRL -- requirements
Module: m_dmem_ctrl

Interface
REQ-001 The module SHALL have port clk, input, 1, rising-edge clock, listed first.
REQ-002 The module SHALL have port rst_n, input, 1, reset; one clock, asynchronous, active-low.
REQ-003 The module SHALL have port M_valid, input, 1, M-stage instruction valid.
REQ-004 The module SHALL have port M_op, input, 4, access opcode: 0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9-15 treated as none.
REQ-005 The module SHALL have port M_ans, input, 32, byte address from the E-stage ALU result.
REQ-006 The module SHALL have port M_Rdata2, input, 32, forwarded store data.
REQ-007 The module SHALL have port M_pc, input, 32, PC of the M-stage instruction.
REQ-008 The module SHALL have the memory-side ports mem_req out 1, mem_we out 1, mem_addr out 32 (word-aligned, bits[1:0]=0), mem_wdata out 32, mem_be out 4, mem_ack in 1 and mem_rdata in 32.
REQ-009 The module SHALL have port M_stall, output, 1, freezes PC/F/D/E/M registers.
REQ-010 The module SHALL have port W_ld_data, output, 32, aligned and extended load result.
REQ-011 The module SHALL have port W_ld_valid, output, 1, one-cycle strobe qualifying W_ld_data.
REQ-012 The module SHALL have ports M_exc, output, 1, and M_exc_pc, output, 32, for misalignment reporting (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, REQ and DONE; access = M_valid && M_op in 1..8.
REQ-014 In IDLE with access, the module SHALL latch the address, op, be and wdata, assert M_stall combinationally and move to REQ.
REQ-015 In REQ, mem_req SHALL be 1 with addr, we, be and wdata held stable, and M_stall SHALL be 1; mem_ack=1 moves the FSM to DONE and registers the load result.
REQ-016 In DONE, M_stall SHALL be 0, W_ld_valid SHALL be 1 for exactly one cycle on loads (0 on stores), and the FSM SHALL return to IDLE next cycle regardless of the inputs.
REQ-017 Minimum latency SHALL be 3 cycles from access to pipeline advance (IDLE, REQ with ack, DONE); each additional REQ cycle without ack adds one cycle.
REQ-018 mem_ack in IDLE or DONE SHALL be ignored; a drop of M_valid during REQ SHALL NOT cancel the transaction.
REQ-019 Stores SHALL drive: SW be=1111 with wdata=Rdata2; SH be=0011 if addr[1]=0 else 1100 with wdata={h,h}; SB be=0001<<addr[1:0] with the byte replicated 4 times.
REQ-020 Loads SHALL select the byte or half by addr[1:0] from mem_rdata; LH and LB sign-extend, LHU and LBU zero-extend, LW passes the word through.
REQ-021 mem_be SHALL be 0000 and mem_we SHALL be 0 whenever mem_req=0.

Reset
REQ-022 While rst_n=0 the module SHALL force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, W_ld_data=0, W_ld_valid=0, M_exc=0 and M_exc_pc=0, and SHALL force M_stall=0.
REQ-023 A reset asserted during REQ SHALL drop mem_req immediately (asynchronously) and abandon the access.

Configuration
REQ-024 The macro M_DMEM_ALIGN_EXC_EN SHALL control misalignment checking.
REQ-025 When M_DMEM_ALIGN_EXC_EN is defined, an LW or SW with addr[1:0]!=0, or an LH, LHU or SH with addr[0]=1, SHALL issue no request, pulse M_exc for one cycle with M_exc_pc=M_pc, assert no stall, and keep the FSM in IDLE.
REQ-026 When M_DMEM_ALIGN_EXC_EN is undefined, the module SHALL ignore addr[1:0] for words and addr[0] for halves, and SHALL tie M_exc=0 and M_exc_pc=0.

Structure
REQ-027 The shared package m_mem_pkg SHALL hold the M_op codes, the FSM state encoding and the byte-enable constants.
REQ-028 A combinational sub-module load_extender (inputs op, addr[1:0], rdata; output 32-bit result) SHALL implement REQ-020.

Verification
REQ-029 The bench SHALL check: LW at 0x0000_0010 with ack in the first REQ cycle -> mem_addr=0x10, be=1111, M_stall high for 2 cycles, W_ld_valid pulse with the data equal to mem_rdata.
REQ-030 The bench SHALL check: LB at 0x13 with mem_rdata=0x80FF_FF7F -> W_ld_data=0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
REQ-031 The bench SHALL check: SH at 0x22 with Rdata2=0x1234_ABCD -> be=1100, wdata=0xABCD_ABCD, we=1, W_ld_valid stays 0.
REQ-032 The bench SHALL check: SW with ack delayed 4 cycles -> req, addr and wdata stable throughout and M_stall high for 5 cycles.
REQ-033 The bench SHALL check: rst_n low in the second REQ cycle -> mem_req=0 at once; after release the FSM is in IDLE and a new LW completes normally.
REQ-034 The bench SHALL check, with M_DMEM_ALIGN_EXC_EN defined, LW at 0x0000_0002 with M_pc=0x3008 -> no mem_req, M_exc pulses one cycle with M_exc_pc=0x3008, and M_stall stays 0.
